// File: rtl/tusca_multizona_ctrl_pkg.sv
// Shared types, reset constants and arithmetic helpers for the multi-zone climate controller.
package tusca_multizona_ctrl_pkg;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    MEDE     = 3'd1,
    ESPERA   = 3'd2,
    ATUALIZA = 3'd3,
    DELAY    = 3'd4
  } poll_state_t;

  typedef enum logic [2:0] {
    CFG_OCIOSO = 3'd0,
    B_ZONA     = 3'd1,
    B_SP       = 3'd2,
    B_HIST     = 3'd3,
    B_CHK      = 3'd4
  } cfg_state_t;

  localparam logic [7:0] SP_RESET   = 8'd25;
  localparam logic [7:0] HIST_RESET = 8'd2;

  function automatic logic [7:0] cfg_checksum(input logic [7:0] zona,
                                               input logic [7:0] sp,
                                               input logic [7:0] hist);
    return zona ^ sp ^ hist;
  endfunction

  // Proportional fan duty: 16-bit product saturated to 8 bits.
  function automatic logic [7:0] calc_duty(input logic [7:0]  temp,
                                           input logic [7:0]  sp,
                                           input logic [15:0] ganho);
    logic [15:0] prod;
    prod = 16'd0;
    if (temp > sp) begin
      prod = {8'd0, temp - sp} * ganho;
    end
    return (prod > 16'd255) ? 8'hFF : prod[7:0];
  endfunction

endpackage

// File: rtl/tusca_multizona_ctrl_canal.sv
// One zone output channel: relay hysteresis register, duty register and PWM comparator.
module tusca_multizona_ctrl_canal
  import tusca_multizona_ctrl_pkg::*;
#(
  parameter int GANHO = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       atualiza,
  input  logic       erro,
  input  logic [7:0] temp,
  input  logic [7:0] sp,
  input  logic [7:0] hist,
  input  logic [7:0] cnt,
  output logic       rele,
  output logic       pwm
);

  logic [7:0] duty_r;
  logic       rele_r;
  logic       pwm_r;
  logic [8:0] limiar_s;

  // Upper threshold kept 9 bits wide so sp+hist never wraps.
  assign limiar_s = {1'b0, sp} + {1'b0, hist};

  // Relay/duty update on this zone's evaluation slot, PWM compare every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      duty_r <= 8'd0;
      rele_r <= 1'b0;
      pwm_r  <= 1'b0;
    end else begin
      if (atualiza) begin
        if (erro) begin
          duty_r <= 8'd0;
          rele_r <= 1'b0;
        end else begin
          duty_r <= calc_duty(temp, sp, 16'(GANHO));
          if ({1'b0, temp} >= limiar_s) begin
            rele_r <= 1'b1;
          end else if (temp <= sp) begin
            rele_r <= 1'b0;
          end
        end
      end
      pwm_r <= (cnt < duty_r);
    end
  end

  assign rele = rele_r;
  assign pwm  = pwm_r;

endmodule

// File: rtl/tusca_multizona_ctrl.sv
// N-zone climate controller: round-robin DHT11 polling, per-zone setpoint table fed by
// serial config frames, relay hysteresis and proportional fan PWM per zone.
module tusca_multizona_ctrl
  import tusca_multizona_ctrl_pkg::*;
#(
  parameter int N_ZONAS      = 4,
  parameter int DELAY_CICLOS = 100000,
  parameter int TIMEOUT      = 50000,
  parameter int PWM_DIV      = 4,
  parameter int GANHO        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               definir_config,
  input  logic [7:0]         config_dado,
  input  logic               config_valida,
  input  logic [7:0]         medida_dado,
  input  logic               medida_valida,
  output logic [N_ZONAS-1:0] medir_dht11_out,
  output logic               erro_config,
  output logic [N_ZONAS-1:0] erro_medida,
  output logic [N_ZONAS-1:0] rele,
  output logic [N_ZONAS-1:0] pwm_ventoinha
);

  localparam int              ZW          = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1;
  localparam logic [31:0]     DELAY_ULT   = 32'(DELAY_CICLOS - 1);
  localparam logic [31:0]     TIMEOUT_ULT = 32'(TIMEOUT - 1);
  localparam logic [31:0]     PWM_ULT     = 32'(PWM_DIV - 1);
  localparam logic [ZW-1:0]   ZONA_ULT    = ZW'(N_ZONAS - 1);
  localparam logic [7:0]      N_ZONAS_B   = 8'(N_ZONAS);

  poll_state_t        poll_r, poll_next_s;
  logic [31:0]        timer_r;
  logic [ZW-1:0]      zona_r;
  logic [N_ZONAS-1:0] medir_r;
  logic [N_ZONAS-1:0] erro_medida_r;
  logic [7:0]         temp_r [N_ZONAS];
  logic [7:0]         sp_r   [N_ZONAS];
  logic [7:0]         hist_r [N_ZONAS];
  logic [31:0]        pre_r;
  logic [7:0]         cnt_r;
  cfg_state_t         cfg_r, cfg_next_s;
  logic [7:0]         cfg_zona_r, cfg_sp_r, cfg_hist_r;
  logic               erro_config_r;
  logic               cfg_aceita_s, cfg_rejeita_s;
  logic [N_ZONAS-1:0] atualiza_s;

  // Poll sequencer next-state.
  always_comb begin
    poll_next_s = poll_r;
    case (poll_r)
      INICIAL:  poll_next_s = MEDE;
      MEDE:     poll_next_s = ESPERA;
      ESPERA: begin
        if (medida_valida || (timer_r == TIMEOUT_ULT)) begin
          poll_next_s = ATUALIZA;
        end else begin
          poll_next_s = ESPERA;
        end
      end
      ATUALIZA: poll_next_s = DELAY;
      DELAY: begin
        if (timer_r == DELAY_ULT) begin
          poll_next_s = MEDE;
        end else begin
          poll_next_s = DELAY;
        end
      end
      default:  poll_next_s = INICIAL;
    endcase
  end

  // Poll state, shared timer, zone pointer, trigger and measurement capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      poll_r        <= INICIAL;
      timer_r       <= 32'd0;
      zona_r        <= '0;
      medir_r       <= '0;
      erro_medida_r <= '0;
      for (int i = 0; i < N_ZONAS; i++) begin
        temp_r[i] <= 8'd0;
      end
    end else begin
      poll_r  <= poll_next_s;
      timer_r <= (poll_next_s == poll_r) ? timer_r + 32'd1 : 32'd0;
      // Trigger is registered so it is high exactly while the FSM sits in MEDE.
      for (int i = 0; i < N_ZONAS; i++) begin
        medir_r[i] <= (poll_next_s == MEDE) && (zona_r == ZW'(i));
      end
      if (poll_r == ESPERA) begin
        if (medida_valida) begin
          temp_r[zona_r]        <= medida_dado;
          erro_medida_r[zona_r] <= 1'b0;
        end else if (timer_r == TIMEOUT_ULT) begin
          erro_medida_r[zona_r] <= 1'b1;
        end
      end
      if (poll_r == ATUALIZA) begin
        zona_r <= (zona_r == ZONA_ULT) ? '0 : zona_r + ZW'(1);
      end
    end
  end

  // Shared PWM prescaler and 8-bit ramp counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_r <= 32'd0;
      cnt_r <= 8'd0;
    end else if (pre_r == PWM_ULT) begin
      pre_r <= 32'd0;
      cnt_r <= cnt_r + 8'd1;
    end else begin
      pre_r <= pre_r + 32'd1;
    end
  end

  // Config frame sequencer next-state and checksum verdict.
  always_comb begin
    cfg_next_s    = cfg_r;
    cfg_aceita_s  = 1'b0;
    cfg_rejeita_s = 1'b0;
    if (definir_config) begin
      cfg_next_s = B_ZONA;
    end else if (config_valida) begin
      case (cfg_r)
        CFG_OCIOSO: cfg_next_s = CFG_OCIOSO;
        B_ZONA:     cfg_next_s = B_SP;
        B_SP:       cfg_next_s = B_HIST;
        B_HIST:     cfg_next_s = B_CHK;
        B_CHK: begin
          cfg_next_s = CFG_OCIOSO;
          if ((cfg_zona_r < N_ZONAS_B) &&
              (cfg_checksum(cfg_zona_r, cfg_sp_r, cfg_hist_r) == config_dado)) begin
            cfg_aceita_s = 1'b1;
          end else begin
            cfg_rejeita_s = 1'b1;
          end
        end
        default:    cfg_next_s = CFG_OCIOSO;
      endcase
    end else begin
      cfg_next_s = cfg_r;
    end
  end

  // Config state, byte capture, error flag and setpoint/hysteresis table.
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_r         <= CFG_OCIOSO;
      cfg_zona_r    <= 8'd0;
      cfg_sp_r      <= 8'd0;
      cfg_hist_r    <= 8'd0;
      erro_config_r <= 1'b0;
      for (int i = 0; i < N_ZONAS; i++) begin
        sp_r[i]   <= SP_RESET;
        hist_r[i] <= HIST_RESET;
      end
    end else begin
      cfg_r <= cfg_next_s;
      if (definir_config) begin
        erro_config_r <= 1'b0;
      end else if (cfg_rejeita_s) begin
        erro_config_r <= 1'b1;
      end
      if (config_valida && !definir_config) begin
        case (cfg_r)
          B_ZONA:  cfg_zona_r <= config_dado;
          B_SP:    cfg_sp_r   <= config_dado;
          B_HIST:  cfg_hist_r <= config_dado;
          default: cfg_zona_r <= cfg_zona_r;
        endcase
      end
      // Same-edge write vs. evaluation: the channel samples the old table value.
      if (cfg_aceita_s) begin
        sp_r[cfg_zona_r[ZW-1:0]]   <= cfg_sp_r;
        hist_r[cfg_zona_r[ZW-1:0]] <= cfg_hist_r;
      end
    end
  end

  for (genvar g = 0; g < N_ZONAS; g++) begin : g_canal
    assign atualiza_s[g] = (poll_r == ATUALIZA) && (zona_r == ZW'(g));

    tusca_multizona_ctrl_canal #(
      .GANHO (GANHO)
    ) u_canal (
      .clock    (clock),
      .reset    (reset),
      .atualiza (atualiza_s[g]),
      .erro     (erro_medida_r[g]),
      .temp     (temp_r[g]),
      .sp       (sp_r[g]),
      .hist     (hist_r[g]),
      .cnt      (cnt_r),
      .rele     (rele[g]),
      .pwm      (pwm_ventoinha[g])
    );
  end

  assign medir_dht11_out = medir_r;
  assign erro_medida     = erro_medida_r;
  assign erro_config     = erro_config_r;

endmodule

// File: tb/tb_tusca_multizona_ctrl.sv
// Randomized self-checking bench for tusca_multizona_ctrl against a per-zone behavioural model.
module tb_tusca_multizona_ctrl;

  localparam int N    = 4;
  localparam int DLY  = 20;
  localparam int TMO  = 30;
  localparam int PDIV = 2;
  localparam int GAN  = 16;
  localparam int POLL_BOUND = DLY + TMO + 20;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         definir_config = 1'b0;
  logic [7:0]   config_dado = 8'd0;
  logic         config_valida = 1'b0;
  logic [7:0]   medida_dado = 8'd0;
  logic         medida_valida = 1'b0;
  logic [N-1:0] medir_dht11_out;
  logic         erro_config;
  logic [N-1:0] erro_medida;
  logic [N-1:0] rele;
  logic [N-1:0] pwm_ventoinha;

  tusca_multizona_ctrl #(
    .N_ZONAS(N), .DELAY_CICLOS(DLY), .TIMEOUT(TMO), .PWM_DIV(PDIV), .GANHO(GAN)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .definir_config  (definir_config),
    .config_dado     (config_dado),
    .config_valida   (config_valida),
    .medida_dado     (medida_dado),
    .medida_valida   (medida_valida),
    .medir_dht11_out (medir_dht11_out),
    .erro_config     (erro_config),
    .erro_medida     (erro_medida),
    .rele            (rele),
    .pwm_ventoinha   (pwm_ventoinha)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state: zone table and expected outputs.
  int m_sp[N], m_hist[N], m_temp[N], m_duty[N];
  bit m_err[N], m_rele[N];
  bit m_erro_cfg;
  int m_ptr;
  int polls_done;

  // Sensor plans.
  int plan_def[N];
  bit plan_en[N];
  int plan_q1[$];
  bit rand_mode;
  bit resp_go;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_atualiza(input int z);
    int diff;
    if (m_err[z]) begin
      m_rele[z] = 1'b0;
      m_duty[z] = 0;
    end else begin
      if (m_temp[z] >= m_sp[z] + m_hist[z]) m_rele[z] = 1'b1;
      else if (m_temp[z] <= m_sp[z]) m_rele[z] = 1'b0;
      diff = m_temp[z] - m_sp[z];
      m_duty[z] = (diff <= 0) ? 0 : ((diff * GAN > 255) ? 255 : diff * GAN);
    end
  endtask

  function automatic logic [N-1:0] vec_rele();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_rele[i];
    return v;
  endfunction

  function automatic logic [N-1:0] vec_err();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_err[i];
    return v;
  endfunction

  // Sensor emulator: answers each trigger, updates the model at the evaluation edge.
  initial begin : responder
    wait (resp_go);
    forever begin
      int z, waited, d, t;
      bit en;
      waited = 0;
      while (medir_dht11_out == '0 && waited < POLL_BOUND) begin
        @(negedge clock);
        waited++;
      end
      if (medir_dht11_out == '0) begin
        check_eq("trig_arrival", 32'd0, 32'd1);
        continue;
      end
      z = m_ptr;
      check_eq("trig_zone", {28'd0, medir_dht11_out}, 32'd1 << z);
      if (rand_mode) begin
        en = ($urandom_range(0, 5) != 0);
        t  = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 80);
      end else begin
        en = plan_en[z];
        t  = (z == 1 && plan_q1.size() > 0) ? plan_q1.pop_front() : plan_def[z];
      end
      @(negedge clock);
      check_eq("trig_width", {28'd0, medir_dht11_out}, 32'd0);
      if (en) begin
        d = $urandom_range(1, TMO - 2);
        repeat (d - 1) @(negedge clock);
        medida_valida = 1'b1;
        medida_dado   = 8'(t);
        @(negedge clock);
        medida_valida = 1'b0;
        @(posedge clock);
        m_temp[z] = t;
        m_err[z]  = 1'b0;
      end else begin
        repeat (TMO + 1) @(posedge clock);
        m_err[z] = 1'b1;
      end
      model_atualiza(z);
      m_ptr = (z + 1) % N;
      polls_done++;
      @(negedge clock);
      check_eq("rele_vec", {28'd0, rele}, {28'd0, vec_rele()});
      check_eq("erro_medida_vec", {28'd0, erro_medida}, {28'd0, vec_err()});
      // Stray strobe during DELAY must not touch anything.
      if ($urandom_range(0, 2) == 0) begin
        medida_valida = 1'b1;
        medida_dado   = 8'($urandom_range(0, 255));
        @(negedge clock);
        medida_valida = 1'b0;
      end
    end
  end

  task automatic wait_polls(input int n);
    int start, budget;
    start  = polls_done;
    budget = 0;
    while (polls_done < start + n && budget < n * (DLY + TMO + 30) + 100) begin
      @(negedge clock);
      budget++;
    end
    check_eq("poll_progress", {31'd0, (polls_done - start >= n)}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    config_valida = 1'b1;
    config_dado   = b;
    @(posedge clock);
    #1;
    config_valida = 1'b0;
  endtask

  task automatic pulse_definir();
    @(negedge clock);
    definir_config = 1'b1;
    @(posedge clock);
    #1;
    definir_config = 1'b0;
    m_erro_cfg = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] zona, input logic [7:0] sp,
                            input logic [7:0] hist, input logic [7:0] chk);
    pulse_definir();
    send_byte(zona);
    send_byte(sp);
    send_byte(hist);
    send_byte(chk);
    if (zona < 8'(N) && (zona ^ sp ^ hist) == chk) begin
      m_sp[zona]   = sp;
      m_hist[zona] = hist;
    end else begin
      m_erro_cfg = 1'b1;
    end
    @(negedge clock);
    check_eq("erro_config", {31'd0, erro_config}, {31'd0, m_erro_cfg});
  endtask

  task automatic measure_pwm(input int z, input int exp_high, input string tag);
    int high;
    high = 0;
    repeat (256 * PDIV) begin
      @(negedge clock);
      if (pwm_ventoinha[z]) high++;
    end
    check_eq(tag, high, exp_high);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] z8, s8, h8, c8;
    for (int i = 0; i < N; i++) begin
      m_sp[i] = 25; m_hist[i] = 2; m_temp[i] = 0; m_duty[i] = 0;
      m_err[i] = 1'b0; m_rele[i] = 1'b0; plan_en[i] = 1'b1;
    end
    m_erro_cfg = 1'b0; m_ptr = 0; polls_done = 0; rand_mode = 1'b0;
    plan_def[0] = 60; plan_def[1] = 27; plan_def[2] = 20; plan_def[3] = 20;
    plan_q1 = '{26, 27, 26, 25};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_rele", {28'd0, rele}, 32'd0);
    check_eq("rst_pwm", {28'd0, pwm_ventoinha}, 32'd0);
    check_eq("rst_medir", {28'd0, medir_dht11_out}, 32'd0);
    check_eq("rst_erro_medida", {28'd0, erro_medida}, 32'd0);
    check_eq("rst_erro_config", {31'd0, erro_config}, 32'd0);
    reset   = 1'b0;
    resp_go = 1'b1;

    // Hysteresis sequence on zone 1 and steady duties for PWM shape.
    wait_polls(20);
    measure_pwm(0, 255 * PDIV, "pwm_sat_255");
    measure_pwm(1, 32 * PDIV, "pwm_duty_32");
    measure_pwm(2, 0, "pwm_zero");

    // Accepted frame rewrites zone 2, rejected ones leave it alone.
    send_frame(8'h02, 8'h1E, 8'h03, 8'h1F);
    plan_def[2] = 33;
    wait_polls(8);
    check_eq("z2_rele_new_sp", {31'd0, rele[2]}, 32'd1);
    measure_pwm(2, 48 * PDIV, "pwm_z2_new_sp");
    send_frame(8'h02, 8'h1E, 8'h03, 8'h00);
    send_frame(8'h05, 8'h1E, 8'h03, 8'h05 ^ 8'h1E ^ 8'h03);
    wait_polls(4);
    measure_pwm(2, 48 * PDIV, "pwm_z2_after_reject");

    // Restart mid-frame clears the sticky flag.
    pulse_definir();
    @(negedge clock);
    check_eq("erro_config_cleared", {31'd0, erro_config}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_frame(8'h03, 8'd18, 8'd0, 8'h03 ^ 8'd18 ^ 8'd0);
    plan_def[3] = 18;
    wait_polls(4);
    check_eq("z3_hist0_boundary", {31'd0, rele[3]}, 32'd1);

    // Missing sensor on zone 3, then recovery.
    plan_en[3] = 1'b0;
    wait_polls(8);
    check_eq("z3_timeout_err", {31'd0, erro_medida[3]}, 32'd1);
    check_eq("z3_timeout_rele", {31'd0, rele[3]}, 32'd0);
    plan_en[3] = 1'b1;
    wait_polls(4);
    check_eq("z3_recover_err", {31'd0, erro_medida[3]}, 32'd0);
    check_eq("z3_recover_rele", {31'd0, rele[3]}, 32'd1);

    // Randomized traffic on both interfaces.
    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_definir();
        repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 255)));
      end
      z8 = 8'($urandom_range(0, 5));
      s8 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(10, 60));
      h8 = 8'($urandom_range(0, 5));
      c8 = ($urandom_range(0, 3) != 0) ? (z8 ^ s8 ^ h8) : 8'($urandom_range(0, 255));
      send_frame(z8, s8, h8, c8);
      wait_polls($urandom_range(0, 2));
    end
    wait_polls(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
